// File: rtl/hls_deadlock_monitor_gen.sv
// rtl/hls_deadlock_monitor_gen.sv - HLS dataflow deadlock monitor with persistence window
// Flags AXIS or sub-instance stalls after HOLD_CYCLES consecutive cycles; optionally sticky.
module hls_deadlock_monitor_gen #(
  parameter  int N_AXIS      = 3,
  parameter  int N_INST      = 2,
  parameter  int HOLD_CYCLES = 1,
  parameter  int CNT_W       = 16,
  parameter  int STICKY      = 0,
  localparam int IDX_W       = $clog2(N_AXIS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic [N_AXIS:0]   block_src,
  output logic [IDX_W-1:0]  first_idx,
  output logic [CNT_W-1:0]  block_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_SUSPECT, S_BLOCKED} state_t;

  state_t             state, state_nxt;
  logic               block_nxt;
  logic [N_AXIS:0]    src_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   entry_idx;
  logic               axis_any, sub_block, raw, enter;

  assign axis_any  = |axis_block_sigs;
  // Sub path stalls only if every instance is blocked or idle and at least one is blocked.
  assign sub_block = (|inst_block_sigs) & (&(inst_block_sigs | inst_idle_sigs));
  assign raw       = axis_any | sub_block;
  assign cnt_inc   = (block_cycles == '1) ? block_cycles : block_cycles + CNT_W'(1);

  always_comb begin
    entry_idx = IDX_W'(N_AXIS);
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) entry_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    block_nxt = block;
    src_nxt   = block_src;
    idx_nxt   = first_idx;
    cnt_nxt   = block_cycles;
    enter     = 1'b0;
    case (state)
      S_IDLE: begin
        if (raw) begin
          cnt_nxt = CNT_W'(1);
          if (HOLD_CYCLES == 1) enter = 1'b1;
          else                  state_nxt = S_SUSPECT;
        end
      end
      S_SUSPECT: begin
        if (!raw) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(HOLD_CYCLES)) enter = 1'b1;
        end
      end
      S_BLOCKED: begin
        if (raw) begin
          cnt_nxt = cnt_inc;
        end else if (STICKY == 0) begin
          state_nxt = S_IDLE;
          block_nxt = 1'b0;
          cnt_nxt   = '0;
          src_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Source snapshot is taken only on the entry edge and frozen afterwards.
    if (enter) begin
      state_nxt = S_BLOCKED;
      block_nxt = 1'b1;
      src_nxt   = {sub_block, axis_block_sigs};
      idx_nxt   = entry_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state        <= S_IDLE;
      block        <= 1'b0;
      block_src    <= '0;
      first_idx    <= '0;
      block_cycles <= '0;
    end else begin
      state        <= state_nxt;
      block        <= block_nxt;
      block_src    <= src_nxt;
      first_idx    <= idx_nxt;
      block_cycles <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// tb/tb_hls_deadlock_monitor_gen.sv - bench for hls_deadlock_monitor_gen
// Four parameterisations share one stimulus stream and are checked against a reference model.
module tb_hls_deadlock_monitor_gen;

  logic       clock;
  logic       reset, clear;
  logic [2:0] axis;
  logic [1:0] ib, ii;

  logic        blk [4];
  logic [3:0]  src [4];
  logic [1:0]  idx [4];
  logic [15:0] bc0, bc1, bc2;
  logic [2:0]  bc3;

  int hold_p  [4] = '{1, 4, 1, 2};
  int sticky_p[4] = '{0, 0, 1, 0};
  int cmax_p  [4] = '{65535, 65535, 65535, 7};

  bit m_blk [4];
  int m_cnt [4];
  int m_src [4];
  int m_idx [4];

  int n_checks = 0;
  int n_fail   = 0;

  hls_deadlock_monitor_gen #(.HOLD_CYCLES(1), .STICKY(0)) d0 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(ii),
    .inst_block_sigs(ib), .clear(clear), .block(blk[0]), .block_src(src[0]),
    .first_idx(idx[0]), .block_cycles(bc0));
  hls_deadlock_monitor_gen #(.HOLD_CYCLES(4), .STICKY(0)) d1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(ii),
    .inst_block_sigs(ib), .clear(clear), .block(blk[1]), .block_src(src[1]),
    .first_idx(idx[1]), .block_cycles(bc1));
  hls_deadlock_monitor_gen #(.HOLD_CYCLES(1), .STICKY(1)) d2 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(ii),
    .inst_block_sigs(ib), .clear(clear), .block(blk[2]), .block_src(src[2]),
    .first_idx(idx[2]), .block_cycles(bc2));
  hls_deadlock_monitor_gen #(.HOLD_CYCLES(2), .STICKY(0), .CNT_W(3)) d3 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(ii),
    .inst_block_sigs(ib), .clear(clear), .block(blk[3]), .block_src(src[3]),
    .first_idx(idx[3]), .block_cycles(bc3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] bc_of(input int k);
    case (k)
      0:       return {16'd0, bc0};
      1:       return {16'd0, bc1};
      2:       return {16'd0, bc2};
      default: return {29'd0, bc3};
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Reference: count consecutive stalled cycles, latch the cause when the window fills.
  task automatic model_edge();
    bit sub, raw;
    int first;
    sub   = (ib != 2'b00) && ((ib | ii) == 2'b11);
    raw   = (axis != 3'b000) || sub;
    first = 0;
    while (first < 3 && !axis[first]) first++;
    for (int k = 0; k < 4; k++) begin
      if (reset || clear) begin
        m_blk[k] = 0; m_cnt[k] = 0; m_src[k] = 0; m_idx[k] = 0;
      end else if (m_blk[k]) begin
        if (raw) m_cnt[k] = (m_cnt[k] + 1 > cmax_p[k]) ? cmax_p[k] : m_cnt[k] + 1;
        else if (sticky_p[k] == 0) begin
          m_blk[k] = 0; m_cnt[k] = 0; m_src[k] = 0; m_idx[k] = 0;
        end
      end else if (raw) begin
        m_cnt[k]++;
        if (m_cnt[k] == hold_p[k]) begin
          m_blk[k] = 1;
          m_src[k] = {28'd0, sub, axis};
          m_idx[k] = first;
        end
      end else begin
        m_cnt[k] = 0;
      end
    end
  endtask

  task automatic step(input logic [2:0] ax, input logic [1:0] b, input logic [1:0] i,
                      input logic clr, input logic rst);
    axis = ax; ib = b; ii = i; clear = clr; reset = rst;
    @(posedge clock);
    model_edge();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("block", k, {31'd0, blk[k]}, {31'd0, m_blk[k]});
      chk("block_src", k, {28'd0, src[k]}, m_src[k]);
      chk("first_idx", k, {30'd0, idx[k]}, m_idx[k]);
      chk("block_cycles", k, bc_of(k), m_cnt[k]);
    end
  endtask

  initial begin
    logic [2:0] ax;
    logic [1:0] b, i;
    int len;
    bit hi;
    axis = 0; ib = 0; ii = 0; clear = 0; reset = 1;
    step(3'b000, 2'b00, 2'b00, 0, 1);
    step(3'b000, 2'b00, 2'b00, 0, 1);
    chk("reset_block", 0, {31'd0, blk[0]}, 0);
    chk("reset_cycles", 0, bc_of(0), 0);

    // Single-cycle AXIS stall on port 2.
    step(3'b000, 2'b00, 2'b00, 0, 0);
    step(3'b100, 2'b00, 2'b00, 0, 0);
    chk("t1_block", 0, {31'd0, blk[0]}, 1);
    chk("t1_src", 0, {28'd0, src[0]}, 32'h4);
    chk("t1_idx", 0, {30'd0, idx[0]}, 2);
    step(3'b000, 2'b00, 2'b00, 0, 0);
    chk("t1_fall", 0, {31'd0, blk[0]}, 0);

    // Sub-instance path: one blocked, the other idle.
    step(3'b000, 2'b01, 2'b10, 0, 0);
    chk("t3_block", 0, {31'd0, blk[0]}, 1);
    chk("t3_src", 0, {28'd0, src[0]}, 32'h8);
    chk("t3_idx", 0, {30'd0, idx[0]}, 3);
    step(3'b000, 2'b01, 2'b00, 0, 0);
    chk("t3_fall", 0, {31'd0, blk[0]}, 0);

    // Persistence window with a one-cycle flicker.
    step(3'b000, 2'b00, 2'b00, 0, 0);
    for (int n = 0; n < 3; n++) step(3'b001, 2'b00, 2'b00, 0, 0);
    chk("t2_burst1", 1, {31'd0, blk[1]}, 0);
    step(3'b000, 2'b00, 2'b00, 0, 0);
    for (int n = 0; n < 3; n++) step(3'b010, 2'b00, 2'b00, 0, 0);
    chk("t2_pre", 1, {31'd0, blk[1]}, 0);
    step(3'b010, 2'b00, 2'b00, 0, 0);
    chk("t2_block", 1, {31'd0, blk[1]}, 1);
    chk("t2_cycles", 1, bc_of(1), 4);

    // Sticky hold, clear release, and clear winning over raw.
    step(3'b000, 2'b00, 2'b00, 1, 0);
    step(3'b001, 2'b00, 2'b00, 0, 0);
    for (int n = 0; n < 10; n++) step(3'b000, 2'b00, 2'b00, 0, 0);
    chk("t4_sticky", 2, {31'd0, blk[2]}, 1);
    chk("t4_frozen", 2, bc_of(2), 1);
    step(3'b000, 2'b00, 2'b00, 1, 0);
    chk("t4_clear", 2, {31'd0, blk[2]}, 0);
    step(3'b001, 2'b00, 2'b00, 0, 0);
    step(3'b001, 2'b00, 2'b00, 1, 0);
    chk("t4_clr_win", 2, {31'd0, blk[2]}, 0);
    step(3'b001, 2'b00, 2'b00, 0, 0);
    chk("t4_redetect", 2, {31'd0, blk[2]}, 1);

    // Saturation of a narrow counter.
    step(3'b000, 2'b00, 2'b00, 1, 0);
    for (int n = 0; n < 20; n++) step(3'b011, 2'b00, 2'b00, 0, 0);
    chk("t5_sat", 3, bc_of(3), 7);
    chk("t5_block", 3, {31'd0, blk[3]}, 1);
    chk("t5_wide", 0, bc_of(0), 20);

    // Reset while sticky-blocked, then redetect.
    step(3'b000, 2'b00, 2'b00, 0, 0);
    step(3'b001, 2'b00, 2'b00, 0, 1);
    chk("t6_block", 2, {31'd0, blk[2]}, 0);
    chk("t6_src", 2, {28'd0, src[2]}, 0);
    chk("t6_cycles", 2, bc_of(2), 0);
    step(3'b001, 2'b00, 2'b00, 0, 0);
    chk("t6_redetect", 2, {31'd0, blk[2]}, 1);

    // Randomised bursts of stalled and clean cycles.
    for (int burst = 0; burst < 80; burst++) begin
      len = $urandom_range(1, 9);
      hi  = $urandom_range(0, 1) == 1;
      for (int n = 0; n < len; n++) begin
        if (hi) begin
          ax = 3'($urandom); b = 2'($urandom); i = 2'($urandom);
          if (ax == 3'b000 && !((b != 2'b00) && ((b | i) == 2'b11)))
            ax = 3'b001 << $urandom_range(0, 2);
        end else begin
          ax = 3'b000; b = 2'b00; i = 2'($urandom);
        end
        step(ax, b, i, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
